// File: rtl/imem_loader.sv
// UART bootloader: receives 8N1 bytes, packs them little-endian into
// 32-bit words and writes them to instruction memory while holding the CPU.
module imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        load_en,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic [15:0] word_count,
  output logic        frame_err,
  output logic        overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [16:0]   CAP  = 17'(1 << DEPTH_LOG2);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    IDLE, LOAD, FINISH
  } ctl_state_t;

  logic          r_rx_s1;
  logic          r_rx_s2;
  rx_state_t     r_rx_state;
  rx_state_t     w_rx_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_byte_vld;
  logic          r_stop_bad;
  logic          w_tick;

  ctl_state_t    r_state;
  ctl_state_t    w_next;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_hold;
  logic [15:0]   r_count;
  logic [1:0]    r_idx;
  logic          r_frame_err;
  logic          r_overflow;

  // the counter holds the cycles left until the next mid-bit sample
  assign w_tick = (r_cnt == ONE);

  // two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // receiver state register
  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  // receiver next-state logic
  always_comb begin
    w_rx_next = r_rx_state;
    unique case (r_rx_state)
      RX_IDLE:  if (!r_rx_s2) w_rx_next = RX_START;
      RX_START: if (w_tick)
                  w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && r_bit == 3'd7)
                  w_rx_next = RX_STOP;
      RX_STOP:  if (w_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // receiver datapath: bit timing, shift register, byte/error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
      r_stop_bad <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_stop_bad <= 1'b0;
      unique case (r_rx_state)
        RX_IDLE: begin
          r_cnt <= HALF;
          r_bit <= '0;
        end
        RX_START: begin
          r_cnt <= w_tick ? FULL : r_cnt - ONE;
        end
        RX_DATA: begin
          if (w_tick) begin
            r_cnt   <= FULL;
            r_shift <= {r_rx_s2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_rx_s2) begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_shift;
            end else begin
              r_stop_bad <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        default: r_cnt <= HALF;
      endcase
    end
  end

  // control state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // control next-state: leave LOAD only once no byte or write is pending
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (load_en) w_next = LOAD;
      LOAD:    if (!load_en && r_rx_state == RX_IDLE &&
                   !r_byte_vld && !r_we)
                 w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // control datapath: word packing, write strobe, address and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_hold      <= 1'b0;
      r_count     <= '0;
      r_idx       <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_stop_bad) r_frame_err <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (load_en) begin
            r_addr      <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_hold      <= 1'b1;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
          end
        end
        LOAD: begin
          if (r_we) begin
            r_addr  <= r_addr + 32'd4;
            r_count <= r_count + 16'd1;
            r_idx   <= '0;
          end else if (r_byte_vld) begin
            r_wdata[{r_idx, 3'b000} +: 8] <= r_byte;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if ({1'b0, r_count} == CAP) r_overflow <= 1'b1;
              else                        r_we       <= 1'b1;
            end
          end
        end
        FINISH: begin
          r_idx  <= '0;
          r_hold <= 1'b0;
        end
        default: r_hold <= 1'b0;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign word_count = r_count;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: UART byte stimulus checked against a
// word-level model of the load session.
module tb_imem_loader;

  localparam int CPB = 4;
  localparam int DL  = 2;
  localparam int CAP = 1 << DL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        load_en = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic [15:0] word_count;
  logic        frame_err;
  logic        overflow;

  imem_loader #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .rx(rx), .load_en(load_en),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .word_count(word_count), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  bit          m_active;
  int          m_count;
  int          m_idx;
  logic [31:0] m_word;
  bit          m_ferr;
  bit          m_ovf;

  logic [7:0] v1[4] = '{8'h13, 8'h05, 8'h10, 8'h00};
  logic [7:0] v2[8] = '{8'h93, 8'h05, 8'h20, 8'h00,
                        8'h33, 8'h86, 8'hB5, 8'h00};

  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      cap_addr.push_back(imem_addr);
      cap_data.push_back(imem_wdata);
      n_cmp++;
      if (prev_we) begin
        n_bad++;
        $display("FAIL we_pulse: imem_we high 2+ cycles, want 1");
      end
    end
    prev_we = imem_we;
  end

  task automatic m_reset();
    m_active = 0; m_count = 0; m_idx = 0;
    m_ferr = 0; m_ovf = 0; m_word = '0;
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic m_session();
    m_active = 1; m_count = 0; m_idx = 0;
    m_ferr = 0; m_ovf = 0;
  endtask

  task automatic m_byte(input logic [7:0] b, input bit stop);
    if (!stop) begin
      m_ferr = 1;
      return;
    end
    if (!m_active) return;
    m_word[8*m_idx +: 8] = b;
    m_idx++;
    if (m_idx == 4) begin
      m_idx = 0;
      if (m_count < CAP) begin
        exp_addr.push_back(32'(4 * m_count));
        exp_data.push_back(m_word);
        m_count++;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    m_byte(b, stop);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++)
      send_byte(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic drop_load(input string tag);
    int k;
    load_en = 1'b0;
    k = 0;
    while (cpu_hold && k < 8) begin
      tick(1);
      k++;
    end
    m_active = 0;
    n_cmp++;
    if (cpu_hold || k > 2) begin
      n_bad++;
      $display("FAIL %s_hold: cpu_hold=%b after %0d cycles, want 0 within 2",
               tag, cpu_hold, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_cmp++;
    if (imem_we !== 1'b0) begin
      n_bad++; $display("FAIL rst_we: got %b want 0", imem_we);
    end
    n_cmp++;
    if (imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL rst_addr: got %h want 0", imem_addr);
    end
    n_cmp++;
    if (imem_wdata !== 32'h0) begin
      n_bad++; $display("FAIL rst_wdata: got %h want 0", imem_wdata);
    end
    n_cmp++;
    if (cpu_hold !== 1'b0) begin
      n_bad++; $display("FAIL rst_hold: got %b want 0", cpu_hold);
    end
    n_cmp++;
    if (word_count !== 16'h0) begin
      n_bad++; $display("FAIL rst_count: got %0d want 0", word_count);
    end
    n_cmp++;
    if (frame_err !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_flags: got ferr=%b ovf=%b want 0 0",
               frame_err, overflow);
    end
    rst = 1'b0;
    m_reset();
    tick(2);
  endtask

  task automatic test_first_word();
    load_en = 1'b1;
    m_session();
    tick(2);
    n_cmp++;
    if (cpu_hold !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL enter: got hold=%b addr=%h want 1 0",
               cpu_hold, imem_addr);
    end
    for (int i = 0; i < 4; i++) send_byte(v1[i], 1'b1);
    n_cmp++;
    if (cap_addr.size() != 1) begin
      n_bad++;
      $display("FAIL w1_nwr: got %0d writes want 1", cap_addr.size());
    end else begin
      n_cmp++;
      if (cap_addr[0] !== 32'h0 || cap_data[0] !== 32'h00100513) begin
        n_bad++;
        $display("FAIL w1_data: got %h@%h want 00100513@0",
                 cap_data[0], cap_addr[0]);
      end
    end
    n_cmp++;
    if (word_count !== 16'd1 || cpu_hold !== 1'b1) begin
      n_bad++;
      $display("FAIL w1_state: got cnt=%0d hold=%b want 1 1",
               word_count, cpu_hold);
    end
    cap_addr.delete(); cap_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic test_more_words();
    for (int i = 0; i < 8; i++) send_byte(v2[i], 1'b1);
    n_cmp++;
    if (cap_addr.size() != exp_addr.size()) begin
      n_bad++;
      $display("FAIL w23_nwr: got %0d writes want %0d",
               cap_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        n_cmp++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL w23_wr%0d: got %h@%h want %h@%h", i,
                   cap_data[i], cap_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    end
    n_cmp++;
    if (imem_wdata !== 32'h00B58633) begin
      n_bad++;
      $display("FAIL w3_data: got %h want 00b58633", imem_wdata);
    end
    n_cmp++;
    if (word_count !== 16'd3 || imem_addr !== 32'hC) begin
      n_bad++;
      $display("FAIL w23_state: got cnt=%0d addr=%h want 3 0000000c",
               word_count, imem_addr);
    end
    cap_addr.delete(); cap_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic test_glitch_ferr();
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    n_cmp++;
    if (cap_addr.size() != 0 || word_count !== 16'(m_count) ||
        frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch: got wr=%0d cnt=%0d ferr=%b want 0 %0d 0",
               cap_addr.size(), word_count, frame_err, m_count);
    end
    send_rand(1);
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    n_cmp++;
    if (frame_err !== 1'b1 || cap_addr.size() != 0) begin
      n_bad++;
      $display("FAIL ferr: got ferr=%b wr=%0d want 1 0",
               frame_err, cap_addr.size());
    end
    send_rand(3);
    n_cmp++;
    if (cap_addr.size() != exp_addr.size()) begin
      n_bad++;
      $display("FAIL ferr_nwr: got %0d writes want %0d",
               cap_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        n_cmp++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL ferr_wr%0d: got %h@%h want %h@%h", i,
                   cap_data[i], cap_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    end
    cap_addr.delete(); cap_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic test_overflow();
    send_rand(4);
    n_cmp++;
    if (cap_addr.size() != 0) begin
      n_bad++;
      $display("FAIL ovf_nwr: got %0d writes want 0", cap_addr.size());
    end
    n_cmp++;
    if (overflow !== m_ovf || imem_addr !== 32'h10 ||
        word_count !== 16'(m_count)) begin
      n_bad++;
      $display("FAIL ovf_state: got ovf=%b addr=%h cnt=%0d want %b 00000010 %0d",
               overflow, imem_addr, word_count, m_ovf, m_count);
    end
    cap_addr.delete(); cap_data.delete();
  endtask

  task automatic test_finish();
    drop_load("fin1");
    send_rand(4);
    n_cmp++;
    if (cap_addr.size() != 0 || word_count !== 16'(m_count) ||
        cpu_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_bytes: got wr=%0d cnt=%0d hold=%b want 0 %0d 0",
               cap_addr.size(), word_count, cpu_hold, m_count);
    end
    load_en = 1'b1;
    m_session();
    tick(2);
    n_cmp++;
    if (imem_addr !== 32'h0 || word_count !== 16'h0 ||
        frame_err !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reenter1: got addr=%h cnt=%0d ferr=%b ovf=%b want 0 0 0 0",
               imem_addr, word_count, frame_err, overflow);
    end
    send_rand(2);
    drop_load("fin2");
    n_cmp++;
    if (cap_addr.size() != 0 || word_count !== 16'h0) begin
      n_bad++;
      $display("FAIL partial: got wr=%0d cnt=%0d want 0 0",
               cap_addr.size(), word_count);
    end
    load_en = 1'b1;
    m_session();
    tick(2);
    n_cmp++;
    if (imem_addr !== 32'h0 || word_count !== 16'h0 ||
        cpu_hold !== 1'b1 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reenter2: got addr=%h cnt=%0d hold=%b flags=%b%b want 0 0 1 00",
               imem_addr, word_count, cpu_hold, frame_err, overflow);
    end
    cap_addr.delete(); cap_data.delete();
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] b;
    send_rand(2);
    b = 8'($urandom_range(0, 255));
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 5; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[5];
    tick(2);
    rst = 1'b1;
    rx = 1'b1;
    load_en = 1'b0;
    tick(2);
    n_cmp++;
    if (imem_we !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0 ||
        cpu_hold !== 1'b0 || word_count !== 16'h0) begin
      n_bad++;
      $display("FAIL midrst: got we=%b addr=%h wd=%h hold=%b cnt=%0d want all 0",
               imem_we, imem_addr, imem_wdata, cpu_hold, word_count);
    end
    m_reset();
    rst = 1'b0;
    tick(CPB * 12);
    load_en = 1'b1;
    m_session();
    tick(2);
    send_rand(4);
    n_cmp++;
    if (cap_addr.size() != 1) begin
      n_bad++;
      $display("FAIL postrst_nwr: got %0d writes want 1", cap_addr.size());
    end else begin
      n_cmp++;
      if (cap_addr[0] !== 32'h0 || cap_data[0] !== exp_data[0]) begin
        n_bad++;
        $display("FAIL postrst_wr: got %h@%h want %h@00000000",
                 cap_data[0], cap_addr[0], exp_data[0]);
      end
    end
    cap_addr.delete(); cap_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++)
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
    n_cmp++;
    if (cap_addr.size() != exp_addr.size()) begin
      n_bad++;
      $display("FAIL b2b_nwr: got %0d writes want %0d",
               cap_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        n_cmp++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL b2b_wr%0d: got %h@%h want %h@%h", i,
                   cap_data[i], cap_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    end
    n_cmp++;
    if (word_count !== 16'(m_count) || imem_addr !== 32'(4 * m_count) ||
        overflow !== m_ovf || frame_err !== m_ferr) begin
      n_bad++;
      $display("FAIL b2b_state: got cnt=%0d addr=%h ovf=%b ferr=%b want %0d %h %b %b",
               word_count, imem_addr, overflow, frame_err,
               m_count, 32'(4 * m_count), m_ovf, m_ferr);
    end
    drop_load("b2b");
  endtask

  initial begin
    m_reset();
    tick(1);
    test_reset();
    test_first_word();
    test_more_words();
    test_glitch_ferr();
    test_overflow();
    test_finish();
    test_reset_midbyte();
    test_back_to_back();
    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
